// File: rtl/multi_sram.sv
// Bank of NUM_SRAMS independent single-port RAMs with registered, write-first,
// sign-extended read ports. Output registers clear asynchronously; memory contents survive reset.
module multi_sram #(
  parameter int NUM_SRAMS      = 8,
  parameter int MAX_ADDR_WIDTH = 10,
  parameter int MAX_DATA_WIDTH = 32,
  parameter int SRAM_WIDTH_O   = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_SRAMS-1:0]                en,
  input  logic [NUM_SRAMS-1:0]                we,
  input  logic [NUM_SRAMS*MAX_ADDR_WIDTH-1:0] addr,
  input  logic [NUM_SRAMS*MAX_DATA_WIDTH-1:0] data_in,
  output logic [NUM_SRAMS*SRAM_WIDTH_O-1:0]   data_out
);

  localparam int DEPTH = 1 << MAX_ADDR_WIDTH;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRAMS; gi++) begin : g_bank
      logic [MAX_DATA_WIDTH-1:0] mem [DEPTH];
      logic [MAX_ADDR_WIDTH-1:0] addr_b;
      logic [MAX_DATA_WIDTH-1:0] wdata_b;
      logic [MAX_DATA_WIDTH-1:0] word_d;
      logic [SRAM_WIDTH_O-1:0]   ext_d;
      logic [SRAM_WIDTH_O-1:0]   dout_q;

      assign addr_b  = addr[gi*MAX_ADDR_WIDTH +: MAX_ADDR_WIDTH];
      assign wdata_b = data_in[gi*MAX_DATA_WIDTH +: MAX_DATA_WIDTH];

      // Write-first: a write cycle presents the incoming word rather than the old contents.
      assign word_d = we[gi] ? wdata_b : mem[addr_b];

      if (SRAM_WIDTH_O > MAX_DATA_WIDTH) begin : g_ext
        assign ext_d = {{(SRAM_WIDTH_O-MAX_DATA_WIDTH){word_d[MAX_DATA_WIDTH-1]}}, word_d};
      end else begin : g_pass
        assign ext_d = word_d;
      end

      // Memory array has no reset; writes are gated by the reset level sampled at the edge.
      always_ff @(posedge clk) begin
        if (rst && en[gi] && we[gi]) begin
          mem[addr_b] <= wdata_b;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dout_q <= '0;
        end else if (en[gi]) begin
          dout_q <= ext_d;
        end
      end

      assign data_out[gi*SRAM_WIDTH_O +: SRAM_WIDTH_O] = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_multi_sram.sv
// Scoreboard bench for multi_sram: stimulus pushes expected outputs, a negedge monitor
// pops and compares. A second narrow instance exercises sign extension.
module tb_multi_sram;
  localparam int N  = 8;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int OW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      en, we;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   din;
  logic [N*OW-1:0]   dout;

  logic              en2, we2;
  logic [3:0]        addr2;
  logic [7:0]        din2;
  logic [31:0]       dout2;

  always #5 clk = ~clk;

  multi_sram #(.NUM_SRAMS(N), .MAX_ADDR_WIDTH(AW), .MAX_DATA_WIDTH(DW), .SRAM_WIDTH_O(OW)) dut (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .data_in(din), .data_out(dout)
  );

  multi_sram #(.NUM_SRAMS(1), .MAX_ADDR_WIDTH(4), .MAX_DATA_WIDTH(8), .SRAM_WIDTH_O(32)) dut_s (
    .clk(clk), .rst(rst), .en(en2), .we(we2), .addr(addr2), .data_in(din2), .data_out(dout2)
  );

  typedef struct {
    string          name;
    logic [N*OW-1:0] exp;
    logic [N*OW-1:0] mask;
    logic [31:0]    exp2;
    logic [31:0]    mask2;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: sparse memories keyed by bank/address plus last presented word per bank.
  logic [31:0] mem_m [int];
  logic [31:0] out_m [N];
  bit          known_m [N];
  logic [7:0]  mem2_m [int];
  logic [31:0] out2_m;
  bit          known2_m;

  // Staging for the next directed cycle
  logic [N-1:0]    st_en, st_we;
  logic [N*AW-1:0] st_addr;
  logic [N*DW-1:0] st_din;
  logic            st_en2, st_we2;
  logic [3:0]      st_addr2;
  logic [7:0]      st_din2;

  task automatic check(input string name, input logic [N*OW-1:0] got,
                       input logic [N*OW-1:0] exp, input logic [N*OW-1:0] mask);
    checks++;
    if ((got & mask) !== (exp & mask)) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h mask=%h", name, got, exp, mask);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, dout, e.exp, e.mask);
        check({e.name, "_narrow"}, {{(N*OW-32){1'b0}}, dout2},
              {{(N*OW-32){1'b0}}, e.exp2}, {{(N*OW-32){1'b0}}, e.mask2});
        $display("txn %-14s data_out=%h narrow=%h", e.name, dout, dout2);
      end
    end
  end

  task automatic cyc(input logic r, input logic [N-1:0] e, input logic [N-1:0] w,
                     input logic [N*AW-1:0] a, input logic [N*DW-1:0] d,
                     input logic e2, input logic w2, input logic [3:0] a2,
                     input logic [7:0] d2, input string name);
    exp_t ent;
    int key;
    @(negedge clk);
    rst = r; en = e; we = w; addr = a; din = d;
    en2 = e2; we2 = w2; addr2 = a2; din2 = d2;
    @(posedge clk);
    #1;
    if (!r) begin
      for (int b = 0; b < N; b++) begin
        out_m[b] = '0; known_m[b] = 1'b1;
      end
      out2_m = '0; known2_m = 1'b1;
    end else begin
      for (int b = 0; b < N; b++) begin
        if (e[b]) begin
          key = b * 4096 + int'(a[b*AW +: AW]);
          if (w[b]) begin
            mem_m[key] = d[b*DW +: DW];
            out_m[b] = d[b*DW +: DW];
            known_m[b] = 1'b1;
          end else if (mem_m.exists(key)) begin
            out_m[b] = mem_m[key];
            known_m[b] = 1'b1;
          end else begin
            known_m[b] = 1'b0;
          end
        end
      end
      if (e2) begin
        if (w2) begin
          mem2_m[int'(a2)] = d2;
          out2_m = {{24{d2[7]}}, d2};
          known2_m = 1'b1;
        end else if (mem2_m.exists(int'(a2))) begin
          out2_m = {{24{mem2_m[int'(a2)][7]}}, mem2_m[int'(a2)]};
          known2_m = 1'b1;
        end else begin
          known2_m = 1'b0;
        end
      end
    end
    ent.name = name;
    for (int b = 0; b < N; b++) begin
      ent.exp[b*OW +: OW]  = out_m[b];
      ent.mask[b*OW +: OW] = known_m[b] ? {OW{1'b1}} : {OW{1'b0}};
    end
    ent.exp2  = out2_m;
    ent.mask2 = known2_m ? 32'hFFFF_FFFF : 32'h0;
    sb.push_back(ent);
  endtask

  task automatic clear_stage();
    st_en = '0; st_we = '0; st_addr = '0; st_din = '0;
    st_en2 = 1'b0; st_we2 = 1'b0; st_addr2 = '0; st_din2 = '0;
  endtask

  task automatic op(input int b, input logic w, input int a, input logic [31:0] d);
    st_en[b] = 1'b1;
    st_we[b] = w;
    st_addr[b*AW +: AW] = AW'(a);
    st_din[b*DW +: DW] = d;
  endtask

  task automatic op2(input logic w, input int a, input logic [7:0] d);
    st_en2 = 1'b1; st_we2 = w; st_addr2 = 4'(a); st_din2 = d;
  endtask

  task automatic go(input logic r, input string name);
    cyc(r, st_en, st_we, st_addr, st_din, st_en2, st_we2, st_addr2, st_din2, name);
    clear_stage();
  endtask

  initial begin : stim
    logic [N-1:0]    re, rw;
    logic [N*AW-1:0] ra;
    logic [N*DW-1:0] rd;
    for (int b = 0; b < N; b++) begin
      out_m[b] = '0; known_m[b] = 1'b0;
    end
    out2_m = '0; known2_m = 1'b0;
    rst = 1'b1; en = '0; we = '0; addr = '0; din = '0;
    en2 = 1'b0; we2 = 1'b0; addr2 = '0; din2 = '0;
    clear_stage();
    #1 rst = 1'b0;

    go(1'b0, "reset0");
    go(1'b0, "reset1");

    // Basic write then read
    op(0, 1'b1, 3, 32'h0000_00A5); go(1'b1, "wr_b0_a3");
    op(0, 1'b0, 3, 32'h0);         go(1'b1, "rd_b0_a3");

    // Two banks, same address, independent contents
    op(2, 1'b1, 7, 32'h1234_5678); op(5, 1'b1, 7, 32'hDEAD_BEEF); go(1'b1, "wr_b2_b5");
    op(2, 1'b0, 7, 32'h0);         op(5, 1'b0, 7, 32'h0);         go(1'b1, "rd_b2_b5");

    // Write-first and hold with bank disabled
    op(1, 1'b1, 0, 32'hFFFF_FFFE); go(1'b1, "wr_first_b1");
    for (int i = 0; i < 3; i++) go(1'b1, "hold_b1");

    // Write ignored when bank disabled
    op(4, 1'b1, 9, 32'h0000_0011); go(1'b1, "wr_b4_a9");
    st_we[4] = 1'b1; st_addr[4*AW +: AW] = AW'(9); st_din[4*DW +: DW] = 32'h77;
    go(1'b1, "we_no_en_b4");
    op(4, 1'b0, 9, 32'h0);         go(1'b1, "rd_b4_a9");

    // Narrow instance sign extension
    op2(1'b1, 2, 8'h80); go(1'b1, "n_wr_80");
    op2(1'b0, 2, 8'h00); go(1'b1, "n_rd_80");
    op2(1'b1, 5, 8'h7F); go(1'b1, "n_wr_7f");
    op2(1'b0, 2, 8'h00); go(1'b1, "n_rd_80b");
    op2(1'b0, 5, 8'h00); go(1'b1, "n_rd_7f");

    // Mid-cycle reset pulse: outputs clear at once, memory is retained
    op(3, 1'b1, 1, 32'h55); op2(1'b1, 6, 8'hC3); go(1'b1, "wr_b3_a1");
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_clear", dout, '0, {(N*OW){1'b1}});
    check("async_rst_clear_narrow", {{(N*OW-32){1'b0}}, dout2}, '0, {(N*OW){1'b1}});
    for (int b = 0; b < N; b++) begin
      out_m[b] = '0; known_m[b] = 1'b1;
    end
    out2_m = '0; known2_m = 1'b1;
    op(3, 1'b1, 1, 32'hAA); op(0, 1'b1, 3, 32'h99); op2(1'b1, 6, 8'h11);
    go(1'b0, "wr_in_reset");
    op(3, 1'b0, 1, 32'h0); op(0, 1'b0, 3, 32'h0); op2(1'b0, 6, 8'h00);
    go(1'b1, "rd_after_rst");

    // Randomized traffic over a small address window so reads hit written words
    for (int i = 0; i < 400; i++) begin
      re = N'($urandom); rw = N'($urandom);
      for (int b = 0; b < N; b++) begin
        ra[b*AW +: AW] = AW'($urandom_range(0, 15));
        rd[b*DW +: DW] = $urandom;
      end
      cyc(1'b1, re, rw, ra, rd, 1'($urandom), 1'($urandom), 4'($urandom_range(0, 15)),
          8'($urandom), "random");
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", sb.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
